// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg: shared definitions for the fp_convert_pipe integer-to-float
// converter.
//   DEF_IN_W / DEF_EXP_W / DEF_SIG_W : default widths of the converter
//   exp_max(exp_w)   : largest exponent representable in exp_w bits
//   lz_width(in_w)   : width needed to hold a leading-zero count of 0..in_w
//   fp_payload_t     : S2 -> S3 payload {s, e, f, rnd, stk, sat}. The e and f
//                      fields are sized for the widest supported configuration.
//                      Narrower builds zero-extend into them and read back only
//                      the low bits.
package fp_conv_pkg;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;

  // Payload field capacity; the top refuses to elaborate beyond these.
  localparam int PL_E_W = 8;
  localparam int PL_F_W = 32;

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int lz_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  typedef struct packed {
    logic              s;
    logic [PL_E_W-1:0] e;
    logic [PL_F_W-1:0] f;
    logic              rnd;
    logic              stk;
    logic              sat;
  } fp_payload_t;

  localparam fp_payload_t PAYLOAD_ZERO = '{
    s:   1'b0,
    e:   8'd0,
    f:   32'd0,
    rnd: 1'b0,
    stk: 1'b0,
    sat: 1'b0
  };

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   data : W-bit word to scan from the MSB down
//   lz   : number of zero bits above the most significant one (W when data == 0)
module fp_lzc #(
  parameter int W     = 12,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data,
  output logic [OUT_W-1:0] lz
);

  logic found_s;

  // Priority scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lz      = OUT_W'(W);
    found_s = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found_s && data[i]) begin
        lz      = OUT_W'(W - 1 - i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_convert_pipe.sv
// fp_convert_pipe: three-stage pipelined conversion of a two's-complement
// integer to sign / exponent / significand (value = F * 2^E), rounding to
// nearest and saturating at the top of the exponent range.
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data is the sample (IN_W bits)
//   out_valid/out_ready  : output handshake
//   out_s/out_e/out_f    : sign, exponent (EXP_W), significand (SIG_W, no hidden bit)
//   out_sat              : result clamped (most-negative input or rounding
//                          overflow at the maximum exponent)
// Build option: define FP_CONVERT_RNE_EN for round-to-nearest-even; the
// default build rounds half-up.
// Stages: S1 sign/magnitude, S2 normalise (shift, round/sticky bits),
// S3 round and output register. Each stage loads when empty or when the stage
// after it loads, so a full pipe streams one word per clock.
module fp_convert_pipe
  import fp_conv_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [SIG_W-1:0] out_f,
  output logic             out_sat
);

  localparam int               LZ_W      = lz_width(IN_W);
  localparam logic [LZ_W-1:0]  SH_BASE   = LZ_W'(IN_W - SIG_W);
  localparam logic [EXP_W-1:0] E_MAX     = EXP_W'(exp_max(EXP_W));
  localparam logic [EXP_W-1:0] ONE_EXP   = EXP_W'(1'b1);
  localparam logic [SIG_W-1:0] ONE_SIG   = SIG_W'(1'b1);
  localparam logic [SIG_W-1:0] F_ONES    = {SIG_W{1'b1}};
  localparam logic [SIG_W-1:0] F_HALF    = ONE_SIG << (SIG_W - 1);
  localparam logic [IN_W-1:0]  ONE_IN    = IN_W'(1'b1);
  localparam logic [IN_W-1:0]  MOST_NEG  = ONE_IN << (IN_W - 1);
  localparam logic [IN_W-1:0]  MAG_CLAMP = ~MOST_NEG;

  // The largest shift is IN_W-SIG_W-1 (the magnitude always has a zero MSB),
  // so the exponent field must be able to hold it.
  if (IN_W - SIG_W - 1 > exp_max(EXP_W)) begin : g_exp_range_err
    $error("fp_convert_pipe: IN_W - SIG_W - 1 exceeds EXP_MAX");
  end
  if (EXP_W > PL_E_W || SIG_W > PL_F_W || SIG_W >= IN_W || SIG_W < 2) begin : g_width_err
    $error("fp_convert_pipe: unsupported EXP_W/SIG_W for this IN_W");
  end

  // ---------------- handshake / stall chain ----------------
  logic v1_r, v2_r;
  logic ld1_s, ld2_s, ld3_s;

  assign ld3_s    = out_ready | ~out_valid;
  assign ld2_s    = ~v2_r | ld3_s;
  assign ld1_s    = ~v1_r | ld2_s;
  assign in_ready = ld1_s;

  // ---------------- S1: sign and magnitude ----------------
  logic            sign_s, sat1_s;
  logic [IN_W-1:0] mag_s;
  logic            s1_sign_r, s1_sat_r;
  logic [IN_W-1:0] s1_mag_r;

  // The most-negative input has no positive twin; clamp it and flag saturation.
  always_comb begin
    sign_s = in_data[IN_W-1];
    if (in_data == MOST_NEG) begin
      mag_s  = MAG_CLAMP;
      sat1_s = 1'b1;
    end else if (sign_s) begin
      mag_s  = ~in_data + ONE_IN;
      sat1_s = 1'b0;
    end else begin
      mag_s  = in_data;
      sat1_s = 1'b0;
    end
  end

  // S1 register: captures a new word whenever the stage is free to load.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      s1_sign_r <= 1'b0;
      s1_sat_r  <= 1'b0;
      s1_mag_r  <= {IN_W{1'b0}};
    end else if (ld1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        s1_sign_r <= sign_s;
        s1_sat_r  <= sat1_s;
        s1_mag_r  <= mag_s;
      end
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LZ_W-1:0]  lz_s;
  logic [LZ_W-1:0]  sh_s;
  logic [SIG_W-1:0] f2_s;
  logic             rnd_s, stk_s;
  fp_payload_t      p2_s;
  fp_payload_t      s2_r;

  fp_lzc #(
    .W     (IN_W),
    .OUT_W (LZ_W)
  ) u_lzc (
    .data (s1_mag_r),
    .lz   (lz_s)
  );

  // Right shift that leaves SIG_W significant bits; small magnitudes get no
  // shift (E = 0). rnd is the first bit shifted out, stk the OR of the rest.
  always_comb begin
    if (lz_s >= SH_BASE) begin
      sh_s = {LZ_W{1'b0}};
    end else begin
      sh_s = SH_BASE - lz_s;
    end
    f2_s  = SIG_W'(s1_mag_r >> sh_s);
    rnd_s = 1'b0;
    stk_s = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (i + 1 == int'(sh_s)) begin
        rnd_s = s1_mag_r[i];
      end else if (i + 2 <= int'(sh_s)) begin
        stk_s = stk_s | s1_mag_r[i];
      end else begin
        rnd_s = rnd_s;
      end
    end
    p2_s     = PAYLOAD_ZERO;
    p2_s.s   = s1_sign_r;
    p2_s.e   = PL_E_W'(sh_s);
    p2_s.f   = PL_F_W'(f2_s);
    p2_s.rnd = rnd_s;
    p2_s.stk = stk_s;
    p2_s.sat = s1_sat_r;
  end

  // S2 register: payload handed to the rounding stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      s2_r <= PAYLOAD_ZERO;
    end else if (ld2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        s2_r <= p2_s;
      end
    end
  end

  // ---------------- S3: round and output register ----------------
  logic [SIG_W-1:0] f_in_s, f3_s;
  logic [EXP_W-1:0] e_in_s, e3_s;
  logic             inc_s, ovf_s;

  // Rounding increment; an all-ones significand renormalises to 1000..0 with
  // E+1, or pins at all-ones/EXP_MAX with saturation when E is already maximal.
  always_comb begin
    f_in_s = s2_r.f[SIG_W-1:0];
    e_in_s = s2_r.e[EXP_W-1:0];
`ifdef FP_CONVERT_RNE_EN
    inc_s  = s2_r.rnd & (s2_r.stk | f_in_s[0]);
`else
    inc_s  = s2_r.rnd;
`endif
    if (!inc_s) begin
      f3_s  = f_in_s;
      e3_s  = e_in_s;
      ovf_s = 1'b0;
    end else if (f_in_s != F_ONES) begin
      f3_s  = f_in_s + ONE_SIG;
      e3_s  = e_in_s;
      ovf_s = 1'b0;
    end else if (e_in_s < E_MAX) begin
      f3_s  = F_HALF;
      e3_s  = e_in_s + ONE_EXP;
      ovf_s = 1'b0;
    end else begin
      f3_s  = F_ONES;
      e3_s  = E_MAX;
      ovf_s = 1'b1;
    end
  end

  // Output register: fields only change when a valid word is loaded, so they
  // stay put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= {EXP_W{1'b0}};
      out_f     <= {SIG_W{1'b0}};
      out_sat   <= 1'b0;
    end else if (ld3_s) begin
      out_valid <= v2_r;
      if (v2_r) begin
        out_s   <= s2_r.s;
        out_e   <= e3_s;
        out_f   <= f3_s;
        out_sat <= s2_r.sat | ovf_s;
      end
    end
  end

  // Payload padding bits (and stk in the half-up build) have no consumer;
  // fold them into one sink so they are not mistaken for dropped logic.
  logic unused_s;
  assign unused_s = ^s2_r;

endmodule
